// File: rtl/striping_pkg.sv
// Shared constants for the byte striping / un-striping pair.
// Lane count, word width, idle filler value and slot encoding.
package striping_pkg;

  localparam int              LANES     = 2;
  localparam int              DATA_W    = 32;
  localparam logic [DATA_W-1:0] IDLE_WORD = 32'h0000_0000;

  typedef enum logic {
    SLOT0 = 1'b0,
    SLOT1 = 1'b1
  } slot_e;

endpackage

// File: rtl/byte_striping_aligner.sv
// Splits a word stream onto two lanes as aligned pairs; bursts always start on lane 0.
// Latency: pair visible two cycles after its lane-0 word; no backpressure, every valid word accepted.
module byte_striping_aligner
  import striping_pkg::*;
#(
  parameter int                DATA_W    = striping_pkg::DATA_W,
  parameter logic [DATA_W-1:0] IDLE_WORD = striping_pkg::IDLE_WORD
) (
  input  logic              clk_2f,
  input  logic              reset_L,
  input  logic [DATA_W-1:0] data_in,
  input  logic              valid_in,
  output logic [DATA_W-1:0] lane_0,
  output logic              valid_0,
  output logic [DATA_W-1:0] lane_1,
  output logic              valid_1,
  output logic              lane_strobe,
  output logic              odd_pad
);

  slot_e             slot_q, slot_nxt;
  logic [DATA_W-1:0] stage_data, stage_data_nxt;
  logic              stage_valid, stage_valid_nxt;
  logic [DATA_W-1:0] lane_0_nxt, lane_1_nxt;
  logic              valid_0_nxt, valid_1_nxt;
  logic              lane_strobe_nxt, odd_pad_nxt;

  always_ff @(posedge clk_2f or negedge reset_L) begin
    if (!reset_L) begin
      slot_q      <= SLOT0;
      stage_data  <= IDLE_WORD;
      stage_valid <= 1'b0;
      lane_0      <= IDLE_WORD;
      lane_1      <= IDLE_WORD;
      valid_0     <= 1'b0;
      valid_1     <= 1'b0;
      lane_strobe <= 1'b0;
      odd_pad     <= 1'b0;
    end else begin
      slot_q      <= slot_nxt;
      stage_data  <= stage_data_nxt;
      stage_valid <= stage_valid_nxt;
      lane_0      <= lane_0_nxt;
      lane_1      <= lane_1_nxt;
      valid_0     <= valid_0_nxt;
      valid_1     <= valid_1_nxt;
      lane_strobe <= lane_strobe_nxt;
      odd_pad     <= odd_pad_nxt;
    end
  end

  always_comb begin
    slot_nxt        = slot_q;
    stage_data_nxt  = stage_data;
    stage_valid_nxt = stage_valid;
    lane_0_nxt      = lane_0;
    lane_1_nxt      = lane_1;
    valid_0_nxt     = valid_0;
    valid_1_nxt     = valid_1;
    lane_strobe_nxt = 1'b0;
    odd_pad_nxt     = 1'b0;
    unique case (slot_q)
      SLOT0: begin
        // Idle never advances the slot, so the next burst starts on lane 0.
        if (valid_in) begin
          stage_data_nxt  = data_in;
          stage_valid_nxt = 1'b1;
          slot_nxt        = SLOT1;
        end else begin
          lane_0_nxt  = IDLE_WORD;
          lane_1_nxt  = IDLE_WORD;
          valid_0_nxt = 1'b0;
          valid_1_nxt = 1'b0;
        end
      end
      SLOT1: begin
        slot_nxt        = SLOT0;
        lane_0_nxt      = stage_data;
        valid_0_nxt     = 1'b1;
        lane_1_nxt      = valid_in ? data_in : IDLE_WORD;
        valid_1_nxt     = valid_in;
        odd_pad_nxt     = ~valid_in;
        lane_strobe_nxt = 1'b1;
        stage_valid_nxt = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_byte_striping_aligner.sv
// Directed bench for byte_striping_aligner with hand-computed per-cycle expectations.
module tb_byte_striping_aligner;
  import striping_pkg::*;

  logic              clk_2f = 1'b0;
  logic              reset_L;
  logic [DATA_W-1:0] data_in;
  logic              valid_in;
  logic [DATA_W-1:0] lane_0, lane_1;
  logic              valid_0, valid_1, lane_strobe, odd_pad;

  int checks = 0;
  int errors = 0;

  localparam logic [DATA_W-1:0] IW = IDLE_WORD;

  byte_striping_aligner dut (
    .clk_2f      (clk_2f),
    .reset_L     (reset_L),
    .data_in     (data_in),
    .valid_in    (valid_in),
    .lane_0      (lane_0),
    .valid_0     (valid_0),
    .lane_1      (lane_1),
    .valid_1     (valid_1),
    .lane_strobe (lane_strobe),
    .odd_pad     (odd_pad)
  );

  always #5 clk_2f = ~clk_2f;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  // flags packed as {lane_strobe, odd_pad, valid_0, valid_1}
  task automatic expect_out(input string tag, input logic [3:0] flags,
                            input logic [DATA_W-1:0] l0, input logic [DATA_W-1:0] l1);
    check({tag, ".flags"}, {60'd0, lane_strobe, odd_pad, valid_0, valid_1}, {60'd0, flags});
    check({tag, ".lanes"}, {lane_0, lane_1}, {l0, l1});
  endtask

  task automatic apply(input logic v, input logic [DATA_W-1:0] d);
    valid_in = v;
    data_in  = d;
    @(posedge clk_2f);
    #1;
  endtask

  initial begin
    reset_L  = 1'b0;
    valid_in = 1'b1;
    data_in  = 32'hFFFF_FFFF;

    // Reset held with valid input active: outputs stay at reset values.
    for (int i = 0; i < 3; i++) begin
      @(posedge clk_2f);
      #1;
      expect_out("reset", 4'b0000, IW, IW);
    end
    reset_L = 1'b1;

    // First word after release lands on lane 0.
    apply(1'b1, 32'h77);
    expect_out("post_rst_slot1", 4'b0000, IW, IW);
    apply(1'b1, 32'h88);
    expect_out("post_rst_pair", 4'b1011, 32'h77, 32'h88);
    apply(1'b0, 32'h0);
    expect_out("post_rst_idle", 4'b0000, IW, IW);

    // Even burst of four words.
    apply(1'b1, 32'h11);
    expect_out("even_w0", 4'b0000, IW, IW);
    apply(1'b1, 32'h22);
    expect_out("even_pair0", 4'b1011, 32'h11, 32'h22);
    apply(1'b1, 32'h33);
    expect_out("even_pair0_hold", 4'b0011, 32'h11, 32'h22);
    apply(1'b1, 32'h44);
    expect_out("even_pair1", 4'b1011, 32'h33, 32'h44);
    apply(1'b0, 32'h0);
    expect_out("even_clear", 4'b0000, IW, IW);

    // Odd burst: third word padded.
    apply(1'b1, 32'hA0);
    apply(1'b1, 32'hA1);
    expect_out("odd_pair0", 4'b1011, 32'hA0, 32'hA1);
    apply(1'b1, 32'hA2);
    expect_out("odd_hold", 4'b0011, 32'hA0, 32'hA1);
    apply(1'b0, 32'h0);
    expect_out("odd_pad", 4'b1110, 32'hA2, IW);
    apply(1'b0, 32'h0);
    expect_out("odd_clear", 4'b0000, IW, IW);

    // Idle gap then a single word: must go to lane 0.
    for (int i = 0; i < 3; i++) begin
      apply(1'b0, 32'h0);
      expect_out("gap_idle", 4'b0000, IW, IW);
    end
    apply(1'b1, 32'hBEEF);
    expect_out("gap_staged", 4'b0000, IW, IW);
    apply(1'b0, 32'h0);
    expect_out("gap_single", 4'b1110, 32'hBEEF, IW);
    apply(1'b0, 32'h0);

    // Reset during the lane-1 slot discards the staged word.
    apply(1'b1, 32'h55);
    valid_in = 1'b0;
    data_in  = 32'h0;
    reset_L  = 1'b0;
    #2;
    expect_out("midrst_async", 4'b0000, IW, IW);
    reset_L = 1'b1;
    @(posedge clk_2f);
    #1;
    expect_out("midrst_no_strobe", 4'b0000, IW, IW);
    apply(1'b1, 32'h66);
    expect_out("midrst_staged", 4'b0000, IW, IW);
    apply(1'b0, 32'h0);
    expect_out("midrst_pair", 4'b1110, 32'h66, IW);
    apply(1'b0, 32'h0);

    // Back-to-back: {1,2,3}, one idle, {4,5}.
    apply(1'b1, 32'h1);
    apply(1'b1, 32'h2);
    expect_out("b2b_pair0", 4'b1011, 32'h1, 32'h2);
    apply(1'b1, 32'h3);
    apply(1'b0, 32'h0);
    expect_out("b2b_pair1", 4'b1110, 32'h3, IW);
    apply(1'b1, 32'h4);
    expect_out("b2b_hold", 4'b0010, 32'h3, IW);
    apply(1'b1, 32'h5);
    expect_out("b2b_pair2", 4'b1011, 32'h4, 32'h5);
    apply(1'b0, 32'h0);
    expect_out("b2b_clear", 4'b0000, IW, IW);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
